serial_parity_receiver: RTL
===========================

SERIAL_PARITY_RECEIVER -- requirements
Module: serial_parity_receiver

Interface
REQ-001 SHALL have parameter: DATA_W, 8, payload bits per frame (legal 2..16).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous reset, active-high.
REQ-004 SHALL have port: sin  input  1  serial bit, sampled only when sin_valid=1.
REQ-005 SHALL have port: sin_valid  input  1  sin carries a bit this cycle.
REQ-006 SHALL have port: out_data  output  DATA_W  assembled payload.
REQ-007 SHALL have port: out_perr  output  1  parity error flag for out_data, valid with out_valid.
REQ-008 SHALL have port: out_valid  output  1  out_data/out_perr held and offered.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts; transfer when out_valid=1 and out_ready=1.
REQ-010 SHALL have port: overrun  output  1  sticky; bit arrived while frame was held.

Function
REQ-011 SHALL use frame format: start bit (1), DATA_W data bits LSB first, one parity bit; bits counted only on sin_valid=1 cycles.
REQ-012 SHALL implement states IDLE, DATA, PARITY, HOLD; all outputs registered.
REQ-013 IDLE: sin_valid=1 and sin=1 -> DATA, bit counter cleared; sin_valid=1 and sin=0 -> stay IDLE (line-idle bit, discarded).
REQ-014 DATA: each accepted bit written to data bit position counter; counter increments; after bit DATA_W-1 -> PARITY.
REQ-015 PARITY: accepted bit p -> HOLD; out_perr = XOR-reduction of data XOR p (even parity, nonzero = error).
REQ-016 SHALL assert out_valid in the first cycle after the parity bit is accepted (latency 1 cycle from parity-bit edge).
REQ-017 HOLD: out_data, out_perr, out_valid stable until transfer; on transfer cycle -> IDLE, out_valid=0 next cycle.
REQ-018 HOLD: any sin_valid=1 cycle (including the transfer cycle) SHALL drop the bit and set overrun=1; no frame assembly begins until IDLE.
REQ-019 overrun SHALL remain 1 until rst; it SHALL NOT affect out_data or out_perr.
REQ-020 sin_valid=0 cycles in any state SHALL cause no state, counter or output change (arbitrary gaps within a frame allowed).
REQ-021 out_ready SHALL be ignored when out_valid=0.
REQ-022 Counter SHALL be ceil(log2(DATA_W)) bits wide minimum; no wrap beyond DATA_W-1.

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE, counter=0, out_data=0, out_perr=0, out_valid=0, overrun=0, regardless of state.
REQ-024 Reset mid-frame or during HOLD SHALL discard the partial/held frame; no transfer is reported for it.
REQ-025 rst SHALL take priority over sin_valid and out_ready in the same cycle.

Configuration
REQ-026 Macro PARITY_ODD_EN: when defined, frames SHALL use odd parity (out_perr = NOT(XOR of data XOR p)); when undefined, even parity per REQ-015.
REQ-027 All other behaviour SHALL be identical with and without PARITY_ODD_EN.

Verification
REQ-028 Even build, DATA_W=8: bits 1, 0xA5 LSB-first, parity 0, contiguous -> out_valid one cycle after parity, out_data=0xA5, out_perr=0.
REQ-029 Same frame, parity 1 -> out_data=0xA5, out_perr=1; PARITY_ODD_EN build: parity 1 -> out_perr=0.
REQ-030 Frame 0x3C with random sin_valid gaps and two leading idle 0 bits -> out_data=0x3C, out_perr=0, exactly one transfer.
REQ-031 Hold out_ready=0 for 5 cycles after out_valid, send 3 bits -> out_data unchanged, overrun=1; out_ready=1 -> transfer, out_valid=0 next cycle, overrun stays 1.
REQ-032 rst after 4 data bits, then full frame 0xFF parity 0 -> out_data=0xFF, out_perr=0, no output for the aborted frame, overrun=0.

Source files
------------

// File: rtl/serial_parity_receiver.sv
// Serial frame receiver: start bit, DATA_W payload bits LSB first, then one parity bit.
// Define PARITY_ODD_EN to check odd parity instead of even parity.
`timescale 1ns / 1ps
module serial_parity_receiver #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  input  logic              sin_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_perr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(DATA_W - 1);

`ifdef PARITY_ODD_EN
  localparam logic OddParity = 1'b1;
`else
  localparam logic OddParity = 1'b0;
`endif

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StData   = 2'd1;
  localparam logic [1:0] StParity = 2'd2;
  localparam logic [1:0] StHold   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_perr_q, out_perr_d;
  logic              out_valid_q, out_valid_d;
  logic              overrun_q, overrun_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    out_data_d  = out_data_q;
    out_perr_d  = out_perr_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    unique case (state_q)
      StIdle: begin
        // A 0 on the line while idle is filler and is dropped.
        if (sin_valid && sin) begin
          state_d = StData;
          cnt_d   = '0;
          asm_d   = '0;
        end
      end
      StData: begin
        if (sin_valid) begin
          asm_d[cnt_q] = sin;
          if (cnt_q == LastIdx) begin
            state_d = StParity;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StParity: begin
        if (sin_valid) begin
          state_d     = StHold;
          out_data_d  = asm_q;
          out_perr_d  = (^asm_q) ^ sin ^ OddParity;
          out_valid_d = 1'b1;
        end
      end
      StHold: begin
        // Bits arriving while a frame is held are lost, even on the transfer cycle.
        if (sin_valid) begin
          overrun_d = 1'b1;
        end
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      asm_q       <= '0;
      out_data_q  <= '0;
      out_perr_q  <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      out_data_q  <= out_data_d;
      out_perr_q  <= out_perr_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_perr  = out_perr_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule
